// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the slow-ROM instruction prefetch controller.
package fetch_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } fetch_state_e;

  localparam int unsigned AW_DEFAULT       = 8;
  localparam int unsigned DW_DEFAULT       = 8;
  localparam int unsigned ROM_WAIT_DEFAULT = 3;
  localparam int unsigned FIFO_DEPTH       = 2;
  // Wait counter must hold ROM_WAIT up to 7; FIFO count must hold 0..FIFO_DEPTH.
  localparam int unsigned WAIT_W           = 3;
  localparam int unsigned CNT_W            = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {instr, pc} prefetch FIFO; entry 0 is always the head so outputs come straight from flops.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    push_data,
  input  logic [AW-1:0]    push_pc,
  output logic [DW-1:0]    head_data,
  output logic [AW-1:0]    head_pc,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [DW-1:0]    data0, data1, data0_nxt, data1_nxt;
  logic [AW-1:0]    pc0, pc1, pc0_nxt, pc1_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Shift-style update: a pop moves entry 1 into the head slot.
  always_comb begin
    data0_nxt = data0;
    data1_nxt = data1;
    pc0_nxt   = pc0;
    pc1_nxt   = pc1;
    cnt_nxt   = count;
    if (flush) begin
      data0_nxt = '0;
      data1_nxt = '0;
      pc0_nxt   = '0;
      pc1_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == CNT_W'(0)) begin
            data0_nxt = push_data;
            pc0_nxt   = push_pc;
          end else begin
            data1_nxt = push_data;
            pc1_nxt   = push_pc;
          end
          cnt_nxt = count + CNT_W'(1);
        end
        2'b01: begin
          data0_nxt = data1;
          pc0_nxt   = pc1;
          cnt_nxt   = count - CNT_W'(1);
        end
        2'b11: begin
          if (count == CNT_W'(1)) begin
            data0_nxt = push_data;
            pc0_nxt   = push_pc;
          end else begin
            data0_nxt = data1;
            pc0_nxt   = pc1;
            data1_nxt = push_data;
            pc1_nxt   = push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data0 <= '0;
      data1 <= '0;
      pc0   <= '0;
      pc1   <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      data0 <= data0_nxt;
      data1 <= data1_nxt;
      pc0   <= pc0_nxt;
      pc1   <= pc1_nxt;
      count <= cnt_nxt;
      valid <= (cnt_nxt != CNT_W'(0));
    end
  end

  assign head_data = data0;
  assign head_pc   = pc0;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch controller for a multi-cycle ROM: sequential prefetch into a 2-deep FIFO with redirect.
module rom_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ROM_WAIT = ROM_WAIT_DEFAULT,
  parameter int unsigned AW       = AW_DEFAULT,
  parameter int unsigned DW       = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  fetch_state_e      state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [AW-1:0]     fetch_pc, pc_nxt;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    cnt_after;
  logic              pop, push;

  assign pop       = instr_valid && instr_ready;
  assign cnt_after = (CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(1) - (CNT_W+1)'(pop);

  // Next-state: redirect restarts an access at the target regardless of state.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    pc_nxt    = fetch_pc;
    push      = 1'b0;
    if (redirect) begin
      state_nxt = ACCESS;
      wait_nxt  = WAIT_W'(1);
      pc_nxt    = redirect_addr;
    end else begin
      case (state)
        IDLE: begin
          if ((fifo_cnt < CNT_W'(FIFO_DEPTH)) || pop) begin
            state_nxt = ACCESS;
            wait_nxt  = WAIT_W'(1);
          end
        end
        ACCESS: begin
          if (wait_cnt == WAIT_W'(ROM_WAIT)) begin
            push   = 1'b1;
            pc_nxt = fetch_pc + AW'(1);
            if (cnt_after == (CNT_W+1)'(FIFO_DEPTH)) begin
              state_nxt = IDLE;
              wait_nxt  = '0;
            end else begin
              wait_nxt = WAIT_W'(1);
            end
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          wait_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      fetch_pc <= '0;
      rom_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      fetch_pc <= pc_nxt;
      rom_en   <= (state_nxt == ACCESS);
    end
  end

  assign rom_addr = fetch_pc;

  fetch_fifo #(
    .AW (AW),
    .DW (DW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .pop       (pop && !redirect),
    .push_data (rom_data),
    .push_pc   (fetch_pc),
    .head_data (instr),
    .head_pc   (instr_pc),
    .valid     (instr_valid),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Randomized bench for rom_fetch_ctrl against a queue-based fetch model with a ROM of rom[a] = a ^ 8'hA5.
module tb_rom_fetch_ctrl;

  localparam int unsigned ROM_WAIT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       redirect = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic       instr_ready = 1'b0;
  logic [7:0] instr, instr_pc, rom_addr, rom_data;
  logic       instr_valid, rom_en;

  rom_fetch_ctrl #(.ROM_WAIT(ROM_WAIT), .AW(8), .DW(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data)
  );

  always #5 clk = ~clk;
  assign rom_data = rom_addr ^ 8'hA5;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] data;
  } ent_t;

  // Model: queued instructions, next fetch address, and the cycle the current access started.
  ent_t       mq[$];
  logic [7:0] m_pc = 8'h00;
  bit         m_busy = 1'b0;
  int         m_start = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input bit r, input bit rd, input logic [7:0] ra, input bit rdy);
    bit pop;
    if (r) begin
      mq.delete();
      m_pc   = 8'h00;
      m_busy = 1'b0;
    end else if (rd) begin
      mq.delete();
      m_pc    = ra;
      m_busy  = 1'b1;
      m_start = cyc + 1;
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (m_busy) begin
        if (cyc - m_start == int'(ROM_WAIT) - 1) begin
          mq.push_back('{pc: m_pc, data: m_pc ^ 8'hA5});
          m_pc    = m_pc + 8'd1;
          m_busy  = (mq.size() < 2);
          m_start = cyc + 1;
        end
      end else if (mq.size() < 2) begin
        m_busy  = 1'b1;
        m_start = cyc + 1;
      end
    end
  endtask

  task automatic tick(input bit r, input bit rd, input logic [7:0] ra, input bit rdy);
    @(negedge clk);
    reset = r; redirect = rd; redirect_addr = ra; instr_ready = rdy;
    @(posedge clk);
    model_step(r, rd, ra, rdy);
    cyc++;
    #1;
    check_eq("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("instr", 32'(instr), 32'(mq[0].data));
      check_eq("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
    end
    check_eq("rom_en", 32'(rom_en), 32'(m_busy));
    if (m_busy || r) check_eq("rom_addr", 32'(rom_addr), 32'(m_pc));
    if (r) begin
      check_eq("rst_instr", 32'(instr), 32'h0);
      check_eq("rst_instr_pc", 32'(instr_pc), 32'h0);
    end
  endtask

  initial begin
    int n;
    // Reset, then measure latency to first instruction.
    repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b1);
    n = 0;
    do begin
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      n++;
    end while (!instr_valid && n < 20);
    check_eq("reset_latency", 32'(n), 32'(ROM_WAIT + 1));
    check_eq("first_instr", 32'(instr), 32'hA5);
    check_eq("first_pc", 32'(instr_pc), 32'h00);
    // Stall the core: FIFO fills with two entries, then drains in order.
    repeat (20) tick(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (12) tick(1'b0, 1'b0, 8'h00, 1'b1);

    // Redirect to 0x40 during wait count 2 of the pc 5 access.
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (17) tick(1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("pc5_in_flight", 32'(rom_addr), 32'h05);
    tick(1'b0, 1'b1, 8'h40, 1'b1);
    n = 1;
    while (!instr_valid && n < 20) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      n++;
    end
    check_eq("redirect_latency", 32'(n), 32'(ROM_WAIT + 1));
    check_eq("redirect_instr", 32'(instr), 32'hE5);
    check_eq("redirect_pc", 32'(instr_pc), 32'h40);

    // Redirect near the top of the address space to exercise wrap.
    tick(1'b0, 1'b1, 8'hFE, 1'b1);
    repeat (14) tick(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset pulse mid-access with one FIFO entry.
    tick(1'b0, 1'b1, 8'h10, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 8'h77, 1'b1);
    repeat (8) tick(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, rd, rdy;
      r   = ($urandom_range(0, 99) < 2);
      rd  = ($urandom_range(0, 99) < 7);
      rdy = ($urandom_range(0, 99) < 65);
      tick(r, rd, 8'($urandom), rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
